vdma_frame_point_ctrl: RTL

VDMA_FRAME_POINT_CTRL -- requirements
Module: vdma_frame_point_ctrl

---
 rtl/vdma_frame_point_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vdma_frame_point_ctrl.sv
// vdma_frame_point_ctrl
// Triple/multi-buffer frame-pointer arbiter between a write VDMA and a read
// VDMA. Each side's vsync rising (active-level) edge marks a frame start.
// The writer always moves to a buffer that the reader is not about to use.
// The reader always takes the newest completely written frame, or repeats
// its current buffer if no new frame has finished since its last read.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   wr_vs, rd_vs  write/read vsync, already in the clk domain
//   wr_point      buffer index for the write VDMA
//   rd_point      buffer index for the read VDMA
//   wr_baseaddr   base address of wr_point (one cycle behind wr_point)
//   rd_baseaddr   base address of rd_point (one cycle behind rd_point)
//   rd_valid      rd_point holds a completely written frame
//   frame_drop    one-cycle pulse: a finished frame was overwritten unread
//   frame_repeat  one-cycle pulse: reader re-reads its previous buffer
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | no frame completed since reset; read edges are ignored
// ST_RUN  | at least one frame completed; reader may take last_done

module vdma_frame_point_ctrl #(
   parameter int          NUM_BUF    = 3,
   parameter int          ADDR_W     = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter logic [31:0] FRAME_SIZE = 32'h0010_0000,
   parameter bit          VS_POL     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_vs,
   input  logic              rd_vs,
   output logic [2:0]        wr_point,
   output logic [2:0]        rd_point,
   output logic [ADDR_W-1:0] wr_baseaddr,
   output logic [ADDR_W-1:0] rd_baseaddr,
   output logic              rd_valid,
   output logic              frame_drop,
   output logic              frame_repeat
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [3:0]        NB     = 4'(NUM_BUF);
   localparam logic [2:0]        LAST   = 3'(NUM_BUF - 1);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] FRM_A  = ADDR_W'(FRAME_SIZE);
   localparam logic [ADDR_W-1:0] RD_RST_ADDR = BASE_A + ADDR_W'(LAST) * FRM_A;

   state_t            state_q, state_d;
   logic              wr_vs_d_q, rd_vs_d_q;
   logic [2:0]        wr_point_q, wr_point_d;
   logic [2:0]        rd_point_q, rd_point_d;
   logic [2:0]        last_done_q, last_done_d;
   logic              fresh_q, fresh_d;
   logic              rd_valid_q, rd_valid_d;
   logic              frame_drop_q, frame_drop_d;
   logic              frame_repeat_q, frame_repeat_d;
   logic [ADDR_W-1:0] wr_baseaddr_q, wr_baseaddr_d;
   logic [ADDR_W-1:0] rd_baseaddr_q, rd_baseaddr_d;

   logic       wr_edge, rd_edge, rd_take;
   logic [2:0] rd_next;
   logic [2:0] wr_sel;
   logic [3:0] cand;
   logic       found;

   assign wr_edge = (wr_vs == VS_POL) && (wr_vs_d_q != VS_POL);
   assign rd_edge = (rd_vs == VS_POL) && (rd_vs_d_q != VS_POL);

   always_comb begin
      state_d        = state_q;
      wr_point_d     = wr_point_q;
      rd_point_d     = rd_point_q;
      last_done_d    = last_done_q;
      fresh_d        = fresh_q;
      rd_valid_d     = rd_valid_q;
      frame_drop_d   = 1'b0;
      frame_repeat_d = 1'b0;
      rd_take        = 1'b0;

      // Reader is serviced first so the writer sees this cycle's rd_point.
      if (rd_edge && state_q == ST_RUN) begin
         if (fresh_q) begin
            rd_take    = 1'b1;
            rd_point_d = last_done_q;
            fresh_d    = 1'b0;
            rd_valid_d = 1'b1;
         end else begin
            frame_repeat_d = 1'b1;
         end
      end
      rd_next = rd_point_d;

      // First buffer after wr_point (circularly) that neither side owns.
      // With NUM_BUF >= 3 one always exists.
      wr_sel = wr_point_q;
      found  = 1'b0;
      cand   = 4'd0;
      for (int i = 1; i < NUM_BUF; i++) begin
         cand = {1'b0, wr_point_q} + 4'(i);
         if (cand >= NB) cand = cand - NB;
         if (!found && cand[2:0] != rd_next && cand[2:0] != wr_point_q) begin
            wr_sel = cand[2:0];
            found  = 1'b1;
         end
      end

      if (wr_edge) begin
         last_done_d  = wr_point_q;
         fresh_d      = 1'b1;
         state_d      = ST_RUN;
         frame_drop_d = fresh_q && !rd_take;
         wr_point_d   = wr_sel;
      end

      wr_baseaddr_d = BASE_A + ADDR_W'(wr_point_q) * FRM_A;
      rd_baseaddr_d = BASE_A + ADDR_W'(rd_point_q) * FRM_A;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_INIT;
         wr_vs_d_q      <= ~VS_POL;
         rd_vs_d_q      <= ~VS_POL;
         wr_point_q     <= 3'd0;
         rd_point_q     <= LAST;
         last_done_q    <= LAST;
         fresh_q        <= 1'b0;
         rd_valid_q     <= 1'b0;
         frame_drop_q   <= 1'b0;
         frame_repeat_q <= 1'b0;
         wr_baseaddr_q  <= BASE_A;
         rd_baseaddr_q  <= RD_RST_ADDR;
      end else begin
         state_q        <= state_d;
         wr_vs_d_q      <= wr_vs;
         rd_vs_d_q      <= rd_vs;
         wr_point_q     <= wr_point_d;
         rd_point_q     <= rd_point_d;
         last_done_q    <= last_done_d;
         fresh_q        <= fresh_d;
         rd_valid_q     <= rd_valid_d;
         frame_drop_q   <= frame_drop_d;
         frame_repeat_q <= frame_repeat_d;
         wr_baseaddr_q  <= wr_baseaddr_d;
         rd_baseaddr_q  <= rd_baseaddr_d;
      end
   end

   assign wr_point     = wr_point_q;
   assign rd_point     = rd_point_q;
   assign wr_baseaddr  = wr_baseaddr_q;
   assign rd_baseaddr  = rd_baseaddr_q;
   assign rd_valid     = rd_valid_q;
   assign frame_drop   = frame_drop_q;
   assign frame_repeat = frame_repeat_q;

endmodule
